// File: rtl/mem_stage_pkg.sv
// Shared constants and bus layouts for the MEM stage: stall encodings, bus widths,
// load opcodes and the packed field layouts of the EX->MEM, MEM->WB and forwarding buses.
package mem_stage_pkg;

    localparam int DATA_W = 32;

    localparam int   StallBus      = 6;
    localparam int   STALL_MEM_BIT = 3;
    localparam int   STALL_WB_BIT  = 4;
    localparam logic Stop          = 1'b1;
    localparam logic NoStop        = 1'b0;

    // The EX bus width is the sum of the ex_to_mem_t fields (147 bits); the field list is authoritative.
    localparam int EX_TO_MEM_WD = 147;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 104;

    typedef enum logic [2:0] {
        MEM_NONE = 3'b000,
        MEM_LB   = 3'b001,
        MEM_LBU  = 3'b010,
        MEM_LH   = 3'b011,
        MEM_LHU  = 3'b100,
        MEM_LW   = 3'b101
    } mem_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic [2:0]  mem_op;
        logic [1:0]  addr_lo;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } mem_to_rf_t;

    function automatic logic is_load_op(input logic [2:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: picks the byte/halfword/word addressed by addr_lo out of the
// read word and sign- or zero-extends it according to mem_op.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_op,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rword[7:0];
        case (addr_lo)
            2'd0:    w_byte = rword[7:0];
            2'd1:    w_byte = rword[15:8];
            2'd2:    w_byte = rword[23:16];
            default: w_byte = rword[31:24];
        endcase
    end

    // Halfword selection deliberately ignores addr_lo[0].
    assign w_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        load_data = '0;
        case (mem_op)
            MEM_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: load_data = {24'd0, w_byte};
            MEM_LH:  load_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: load_data = {16'd0, w_half};
            MEM_LW:  load_data = rword;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, keeps one-cycle SRAM read data alive across
// MEM stalls, and drives the MEM->WB bus and the ID forwarding bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [DATA_W-1:0]       data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    ex_to_mem_t        r_bus_p1;
    logic [DATA_W-1:0] r_rdata_hold_p1;
    logic              r_held_p1;

    logic              w_bubble;
    logic              w_advance;
    logic              w_is_load;
    logic [DATA_W-1:0] w_rword;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_rf_wdata;
    logic              w_stall_unused;
    mem_to_wb_t        w_wb;
    mem_to_rf_t        w_rf;

    assign w_bubble  = (stall[STALL_MEM_BIT] == Stop) && (stall[STALL_WB_BIT] == NoStop);
    assign w_advance = (stall[STALL_MEM_BIT] == NoStop);
    assign w_is_load = r_bus_p1.data_ram_en && (r_bus_p1.data_ram_wen == 4'b0000);
    assign w_stall_unused = ^{stall[5], stall[2:0]};

    // ---- EX -> MEM register boundary ----
    // The bubble takes priority over capturing read data; any load of the bus drops the held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_p1        <= '0;
            r_rdata_hold_p1 <= '0;
            r_held_p1       <= 1'b0;
        end else if (w_bubble) begin
            r_bus_p1  <= '0;
            r_held_p1 <= 1'b0;
        end else if (w_advance) begin
            r_bus_p1  <= ex_to_mem_bus;
            r_held_p1 <= 1'b0;
        end else if (!r_held_p1 && w_is_load) begin
            r_rdata_hold_p1 <= data_sram_rdata;
            r_held_p1       <= 1'b1;
        end
    end

    assign w_rword = r_held_p1 ? r_rdata_hold_p1 : data_sram_rdata;

    load_ext u_load_ext (
        .rword     (w_rword),
        .addr_lo   (r_bus_p1.addr_lo),
        .mem_op    (r_bus_p1.mem_op),
        .load_data (w_load_data)
    );

    assign w_rf_wdata = (r_bus_p1.sel_rf_res && is_load_op(r_bus_p1.mem_op))
                        ? w_load_data : r_bus_p1.ex_result;

    always_comb begin
        w_wb          = '0;
        w_wb.pc       = r_bus_p1.pc;
        w_wb.rf_we    = r_bus_p1.rf_we;
        w_wb.rf_waddr = r_bus_p1.rf_waddr;
        w_wb.rf_wdata = w_rf_wdata;
        w_wb.hi_we    = r_bus_p1.hi_we;
        w_wb.lo_we    = r_bus_p1.lo_we;
        w_wb.hi       = r_bus_p1.hi;
        w_wb.lo       = r_bus_p1.lo;
    end

    always_comb begin
        w_rf          = '0;
        w_rf.rf_we    = w_wb.rf_we;
        w_rf.rf_waddr = w_wb.rf_waddr;
        w_rf.rf_wdata = w_wb.rf_wdata;
        w_rf.hi_we    = w_wb.hi_we;
        w_rf.lo_we    = w_wb.lo_we;
        w_rf.hi       = w_wb.hi;
        w_rf.lo       = w_wb.lo;
    end

    assign mem_to_wb_bus = w_wb;
    assign mem_to_rf_bus = w_rf;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-load vectors plus hand-written
// sequences for stall hold, bubbles and asynchronous reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [146:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_rf_bus;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [1:0]  alo;
        logic        sel;
        logic [31:0] exres;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [146:0] mk_ex(
        input logic [31:0] pc, input logic en, input logic [3:0] wen, input logic sel,
        input logic [2:0] op, input logic [1:0] alo, input logic we, input logic [4:0] waddr,
        input logic [31:0] exres, input logic hiwe, input logic lowe,
        input logic [31:0] hi, input logic [31:0] lo);
        return {pc, en, wen, sel, op, alo, we, waddr, exres, hiwe, lowe, hi, lo};
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [31:0] pc, input logic we,
        input logic [4:0] waddr, input logic [31:0] wdata, input logic hiwe, input logic lowe,
        input logic [31:0] hi, input logic [31:0] lo);
        logic [135:0] e;
        e = {pc, we, waddr, wdata, hiwe, lowe, hi, lo};
        check({name, ".wb"}, mem_to_wb_bus, e);
        check({name, ".rf"}, {32'd0, mem_to_rf_bus}, {32'd0, e[103:0]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"lb_a3",     MEM_LB,  2'd3, 1'b1, 32'h0, 32'h80123456, 32'hFFFFFF80};
        vecs[1]  = '{"lbu_a3",    MEM_LBU, 2'd3, 1'b1, 32'h0, 32'h80123456, 32'h00000080};
        vecs[2]  = '{"lh_a2",     MEM_LH,  2'd2, 1'b1, 32'h0, 32'h80017FFF, 32'hFFFF8001};
        vecs[3]  = '{"lhu_a0",    MEM_LHU, 2'd0, 1'b1, 32'h0, 32'h80017FFF, 32'h00007FFF};
        vecs[4]  = '{"lh_a3",     MEM_LH,  2'd3, 1'b1, 32'h0, 32'h80017FFF, 32'hFFFF8001};
        vecs[5]  = '{"lb_a0",     MEM_LB,  2'd0, 1'b1, 32'h0, 32'h80017FFF, 32'hFFFFFFFF};
        vecs[6]  = '{"lbu_a1",    MEM_LBU, 2'd1, 1'b1, 32'h0, 32'h80017FFF, 32'h0000007F};
        vecs[7]  = '{"lb_a2",     MEM_LB,  2'd2, 1'b1, 32'h0, 32'h80017FFF, 32'h00000001};
        vecs[8]  = '{"lw",        MEM_LW,  2'd0, 1'b1, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[9]  = '{"op110",     3'b110,  2'd0, 1'b1, 32'h11112222, 32'hFFFFFFFF, 32'h11112222};
        vecs[10] = '{"lw_nosel",  MEM_LW,  2'd0, 1'b0, 32'h33334444, 32'hFFFFFFFF, 32'h33334444};
        vecs[11] = '{"lhu_a2",    MEM_LHU, 2'd2, 1'b1, 32'h0, 32'h80017FFF, 32'h00008001};

        rst             = 1'b0;
        stall           = 6'b000000;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'h0;
        #2;
        check_both("reset", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #10;
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            ex_to_mem_bus = mk_ex(32'h1000 + 32'(i * 4), 1'b1, 4'b0000, vecs[i].sel, vecs[i].op,
                                  vecs[i].alo, 1'b1, 5'(i + 1), vecs[i].exres, 1'b0, 1'b1,
                                  32'h0, 32'h0F0F0F0F);
            stall = 6'b000000;
            step();
            data_sram_rdata = vecs[i].rdata;
            #1;
            check_both(vecs[i].name, 32'h1000 + 32'(i * 4), 1'b1, 5'(i + 1), vecs[i].exp,
                       1'b0, 1'b1, 32'h0, 32'h0F0F0F0F);
        end

        // lw held across a 3-cycle MEM+WB stall while the SRAM output drops to zero
        ex_to_mem_bus = mk_ex(32'h2000, 1'b1, 4'b0000, 1'b1, MEM_LW, 2'd0, 1'b1, 5'd9,
                              32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        stall = 6'b000000;
        step();
        data_sram_rdata = 32'hDEADBEEF;
        stall = 6'b011000;
        ex_to_mem_bus = mk_ex(32'h2FFC, 1'b0, 4'b0000, 1'b0, 3'b000, 2'd0, 1'b1, 5'd31,
                              32'h77777777, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_both("hold_c0", 32'h2000, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step();
            data_sram_rdata = 32'h0;
            #1;
            check_both($sformatf("hold_c%0d", k), 32'h2000, 1'b1, 5'd9, 32'hDEADBEEF,
                       1'b0, 1'b0, 32'h0, 32'h0);
        end

        // bubble while a word is held, then a fresh load must use live SRAM data
        stall = 6'b001000;
        step();
        check_both("bubble_over_hold", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        ex_to_mem_bus = mk_ex(32'h2004, 1'b1, 4'b0000, 1'b1, MEM_LW, 2'd0, 1'b1, 5'd10,
                              32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        stall = 6'b000000;
        step();
        data_sram_rdata = 32'hCAFEF00D;
        #1;
        check_both("fresh_after_bubble", 32'h2004, 1'b1, 5'd10, 32'hCAFEF00D,
                   1'b0, 1'b0, 32'h0, 32'h0);

        // ALU result passthrough, stall-hold, then stall=001111 bubble
        ex_to_mem_bus = mk_ex(32'h3000, 1'b0, 4'b0000, 1'b0, 3'b000, 2'd0, 1'b1, 5'd5,
                              32'h12345678, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0);
        stall = 6'b000000;
        step();
        check_both("alu", 32'h3000, 1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0);
        ex_to_mem_bus = '0;
        stall = 6'b011000;
        step();
        check_both("alu_stalled", 32'h3000, 1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0,
                   32'hA5A5A5A5, 32'h0);
        stall = 6'b001111;
        step();
        check_both("bubble_001111", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // asynchronous reset in the middle of a load stall
        ex_to_mem_bus = mk_ex(32'h4000, 1'b1, 4'b0000, 1'b1, MEM_LW, 2'd0, 1'b1, 5'd12,
                              32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        stall = 6'b000000;
        step();
        data_sram_rdata = 32'h11223344;
        stall = 6'b011000;
        #1;
        check_both("pre_rst_c0", 32'h4000, 1'b1, 5'd12, 32'h11223344, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        data_sram_rdata = 32'h0;
        #1;
        check_both("pre_rst_c1", 32'h4000, 1'b1, 5'd12, 32'h11223344, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        check_both("rst_async", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        stall = 6'b000000;
        ex_to_mem_bus = mk_ex(32'h4004, 1'b0, 4'b0000, 1'b0, 3'b000, 2'd0, 1'b1, 5'd13,
                              32'h55AA55AA, 1'b0, 1'b1, 32'h0, 32'h13572468);
        step();
        check_both("post_rst", 32'h4004, 1'b1, 5'd13, 32'h55AA55AA, 1'b0, 1'b1,
                   32'h0, 32'h13572468);
        ex_to_mem_bus = mk_ex(32'h4008, 1'b1, 4'b0000, 1'b1, MEM_LW, 2'd0, 1'b1, 5'd14,
                              32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        data_sram_rdata = 32'h99887766;
        stall = 6'b011000;
        #1;
        check_both("post_rst_ld_c0", 32'h4008, 1'b1, 5'd14, 32'h99887766, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        data_sram_rdata = 32'h0;
        #1;
        check_both("post_rst_ld_c1", 32'h4008, 1'b1, 5'd14, 32'h99887766, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
